// File: rtl/mem_seq_pkg.sv
// Shared types and helpers for the memory port sequencer.
package mem_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAPT,
        WR,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    // Byte-enable mask for an access of the given size starting at byte lane off.
    function automatic logic [63:0] lane_mask(size_e size, logic [2:0] off);
        logic [63:0] m;
        unique case (size)
            SZ_B:    m = 64'h0000_0000_0000_00FF;
            SZ_H:    m = 64'h0000_0000_0000_FFFF;
            SZ_W:    m = 64'h0000_0000_FFFF_FFFF;
            default: m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return m << {off, 3'b000};
    endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational byte-lane merge for sub-dword stores plus alignment check.
module store_merge
    import mem_seq_pkg::*;
(
    input  logic [63:0] old_i,
    input  logic [63:0] wdata_i,
    input  size_e       size_i,
    input  logic [2:0]  off_i,
    output logic [63:0] merged_o,
    output logic        misalign_o
);

    logic [63:0] mask;

    // Insert the right-justified store data into the addressed lanes and flag bad alignment.
    always_comb begin
        mask       = lane_mask(size_i, off_i);
        merged_o   = (old_i & ~mask) | ((wdata_i << {off_i, 3'b000}) & mask);
        misalign_o = 1'b0;
        unique case (size_i)
            SZ_B:    misalign_o = 1'b0;
            SZ_H:    misalign_o = off_i[0];
            SZ_W:    misalign_o = |off_i[1:0];
            default: misalign_o = |off_i;
        endcase
    end

endmodule

// File: rtl/mem_port_sequencer.sv
// Shares one registered 64-bit memory port between instruction fetch and load/store,
// with round-robin arbitration, read-latency sequencing and read-modify-write stores.
module mem_port_sequencer
    import mem_seq_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(MEM_LAT - 1);

    state_e            state_q;
    owner_e            owner_q;
    owner_e            last_grant_q;
    size_e             size_q;
    logic              we_q;
    logic [2:0]        off_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CntW-1:0]   cnt_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              if_done_q;
    logic              d_done_q;
    logic              d_misalign_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_wr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic              grant_if;
    size_e             size_sel;
    logic [2:0]        off_sel;
    logic [DATA_W-1:0] merged;
    logic              misalign;
    logic [DATA_W-1:0] rd_shifted;

    // Arbitration and merge-unit input selection: live request in IDLE, latched otherwise.
    always_comb begin
        grant_if   = if_req && (!d_req || (last_grant_q == OWN_D));
        size_sel   = (state_q == IDLE) ? size_e'(d_size) : size_q;
        off_sel    = (state_q == IDLE) ? d_addr[2:0] : off_q;
        rd_shifted = mem_rdata >> {off_q, 3'b000};
    end

    store_merge u_store_merge (
        .old_i      (mem_rdata),
        .wdata_i    (wdata_q),
        .size_i     (size_sel),
        .off_i      (off_sel),
        .merged_o   (merged),
        .misalign_o (misalign)
    );

    // Sequencer FSM with registered memory-port and completion outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IF;
            last_grant_q <= OWN_D;
            size_q       <= SZ_B;
            we_q         <= 1'b0;
            off_q        <= 3'b000;
            wdata_q      <= '0;
            cnt_q        <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            if_done_q    <= 1'b0;
            d_done_q     <= 1'b0;
            d_misalign_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_wr_q     <= 1'b0;
            mem_wdata_q  <= '0;
        end else begin
            // Completion flags are single-cycle pulses raised on entry to DONE.
            if_done_q    <= 1'b0;
            d_done_q     <= 1'b0;
            d_misalign_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (grant_if) begin
                        owner_q      <= OWN_IF;
                        last_grant_q <= OWN_IF;
                        we_q         <= 1'b0;
                        off_q        <= if_addr[2:0];
                        mem_addr_q   <= {if_addr[ADDR_W-1:3], 3'b000};
                        state_q      <= RD;
                    end else if (d_req) begin
                        owner_q      <= OWN_D;
                        last_grant_q <= OWN_D;
                        we_q         <= d_we;
                        size_q       <= size_e'(d_size);
                        off_q        <= d_addr[2:0];
                        wdata_q      <= d_wdata;
                        if (misalign) begin
                            d_done_q     <= 1'b1;
                            d_misalign_q <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            mem_addr_q <= {d_addr[ADDR_W-1:3], 3'b000};
                            if (d_we && (d_size == SZ_D)) begin
                                mem_wdata_q <= d_wdata;
                                mem_wr_q    <= 1'b1;
                                state_q     <= WR;
                            end else begin
                                state_q <= RD;
                            end
                        end
                    end
                end
                RD: begin
                    if (cnt_q == LastCnt) begin
                        state_q <= CAPT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                CAPT: begin
                    if (we_q) begin
                        mem_wdata_q <= merged;
                        mem_wr_q    <= 1'b1;
                        state_q     <= WR;
                    end else begin
                        if (owner_q == OWN_IF) begin
                            if_rdata_q <= rd_shifted;
                            if_done_q  <= 1'b1;
                        end else begin
                            d_rdata_q <= rd_shifted;
                            d_done_q  <= 1'b1;
                        end
                        state_q <= DONE;
                    end
                end
                WR: begin
                    mem_wr_q <= 1'b0;
                    d_done_q <= 1'b1;
                    state_q  <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign if_rdata   = if_rdata_q;
    assign if_done    = if_done_q;
    assign d_rdata    = d_rdata_q;
    assign d_done     = d_done_q;
    assign d_misalign = d_misalign_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wr     = mem_wr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Self-checking bench for mem_port_sequencer against a byte-level memory reference model.
module tb_mem_port_sequencer;

    localparam int unsigned LAT = 1;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [63:0] if_rdata;
    logic        if_done;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [63:0] d_wdata;
    logic [63:0] d_rdata;
    logic        d_done;
    logic        d_misalign;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        busy;

    logic [63:0] mem     [16];
    logic [63:0] ref_mem [16];
    logic        pl_en;
    logic [3:0]  pl_idx;
    logic [63:0] pl_data;

    logic [63:0] exp_if_rdata;
    logic [63:0] exp_d_rdata;
    logic [63:0] last_wr_data;
    int          n_checks;
    int          n_fail;

    mem_port_sequencer #(
        .ADDR_W  (32),
        .DATA_W  (64),
        .MEM_LAT (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_done    (if_done),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_size     (d_size),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_done     (d_done),
        .d_misalign (d_misalign),
        .mem_addr   (mem_addr),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered memory: one-cycle read, write on mem_wr.
    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (mem_wr) mem[mem_addr[6:3]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[6:3]];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_fetch(input logic [31:0] addr);
        logic [63:0] exp;
        int cyc;
        int wr_cnt;
        int both;
        exp    = ref_mem[addr[6:3]] >> (8 * addr[2:0]);
        cyc    = 0;
        wr_cnt = 0;
        both   = 0;
        if_addr = addr;
        if_req  = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (mem_wr) wr_cnt++;
            if (if_done || d_done) begin
                cyc  = c;
                both = (if_done && d_done) ? 1 : 0;
                break;
            end
        end
        if_req = 1'b0;
        chk("fetch_latency", 64'(cyc), 64'(LAT + 2));
        chk("fetch_single_done", 64'(both), 64'd0);
        chk("fetch_rdata", if_rdata, exp);
        chk("fetch_no_write", 64'(wr_cnt), 64'd0);
        chk("fetch_d_rdata_held", d_rdata, exp_d_rdata);
        exp_if_rdata = exp;
        @(posedge clk); #1;
        chk("fetch_back_idle", 64'(busy), 64'd0);
    endtask

    task automatic do_data(input logic we, input logic [1:0] size, input logic [31:0] addr,
                           input logic [63:0] wdata);
        int          nb;
        int          off;
        int          mis;
        int          lat;
        int          cyc;
        int          wr_cnt;
        int          wr_cyc;
        logic [63:0] word;
        logic [63:0] wr_addr;
        nb   = 1 << size;
        off  = int'(addr[2:0]);
        mis  = ((addr % nb) != 0) ? 1 : 0;
        word = ref_mem[addr[6:3]];
        if (mis != 0)       lat = 1;
        else if (!we)       lat = LAT + 2;
        else if (size == 3) lat = 2;
        else                lat = LAT + 3;
        cyc     = 0;
        wr_cnt  = 0;
        wr_cyc  = 0;
        wr_addr = '0;
        d_we    = we;
        d_size  = size;
        d_addr  = addr;
        d_wdata = wdata;
        d_req   = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (mem_wr) begin
                wr_cnt++;
                wr_cyc       = c;
                wr_addr      = 64'(mem_addr);
                last_wr_data = mem_wdata;
            end
            if (if_done || d_done) begin
                cyc = c;
                break;
            end
        end
        d_req = 1'b0;
        chk("data_latency", 64'(cyc), 64'(lat));
        chk("data_if_done_low", 64'(if_done), 64'd0);
        chk("data_misalign", 64'(d_misalign), 64'(mis));
        chk("data_if_rdata_held", if_rdata, exp_if_rdata);
        if (mis == 0 && we) begin
            for (int b = 0; b < nb; b++) word[8 * (off + b) +: 8] = wdata[8 * b +: 8];
            ref_mem[addr[6:3]] = word;
            chk("store_write_count", 64'(wr_cnt), 64'd1);
            chk("store_write_cycle", 64'(wr_cyc), 64'(lat - 1));
            chk("store_write_addr", wr_addr, 64'({addr[31:3], 3'b000}));
            chk("store_write_data", last_wr_data, word);
        end else begin
            chk("data_no_write", 64'(wr_cnt), 64'd0);
        end
        if (mis == 0 && !we) exp_d_rdata = word >> (8 * off);
        chk("data_d_rdata", d_rdata, exp_d_rdata);
        @(posedge clk); #1;
        chk("data_back_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [63:0] v;
        int          order [3];
        int          when  [3];
        int          n_done;
        logic [1:0]  rs;
        logic [31:0] ra;

        n_checks     = 0;
        n_fail       = 0;
        reset        = 1'b1;
        if_req       = 1'b0;
        if_addr      = '0;
        d_req        = 1'b0;
        d_we         = 1'b0;
        d_size       = 2'd0;
        d_addr       = '0;
        d_wdata      = '0;
        pl_en        = 1'b0;
        pl_idx       = '0;
        pl_data      = '0;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
        last_wr_data = '0;

        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            v = (k == 2) ? 64'h1122_3344_5566_7788 : {$urandom, $urandom};
            pl_en      = 1'b1;
            pl_idx     = 4'(k);
            pl_data    = v;
            ref_mem[k] = v;
        end
        @(posedge clk); #1;
        pl_en = 1'b0;
        reset = 1'b0;

        // Reset state.
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_if_rdata", if_rdata, 64'd0);
        chk("rst_d_rdata", d_rdata, 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_mem_wr", 64'(mem_wr), 64'd0);
        chk("rst_dones", 64'({if_done, d_done, d_misalign}), 64'd0);

        // Both requesters held from reset: fetch first, then strict alternation.
        if_addr = 32'h10;
        d_addr  = 32'h18;
        d_we    = 1'b0;
        d_size  = 2'd3;
        if_req  = 1'b1;
        d_req   = 1'b1;
        n_done  = 0;
        for (int k = 0; k < 3; k++) begin
            order[k] = -1;
            when[k]  = 0;
        end
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            chk("rr_no_write", 64'(mem_wr), 64'd0);
            chk("rr_single_done", 64'(if_done && d_done), 64'd0);
            if (if_done || d_done) begin
                order[n_done] = if_done ? 0 : 1;
                when[n_done]  = c;
                n_done++;
                if (n_done == 3) begin
                    if_req = 1'b0;
                    d_req  = 1'b0;
                    break;
                end
            end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        chk("rr_first_owner", 64'(order[0]), 64'd0);
        chk("rr_first_cycle", 64'(when[0]), 64'(LAT + 2));
        chk("rr_second_owner", 64'(order[1]), 64'd1);
        chk("rr_second_cycle", 64'(when[1]), 64'(2 * LAT + 5));
        chk("rr_third_owner", 64'(order[2]), 64'd0);
        chk("rr_third_cycle", 64'(when[2]), 64'(3 * LAT + 8));
        chk("rr_if_rdata", if_rdata, 64'h1122_3344_5566_7788);
        chk("rr_d_rdata", d_rdata, ref_mem[3]);
        exp_if_rdata = 64'h1122_3344_5566_7788;
        exp_d_rdata  = ref_mem[3];
        @(posedge clk); #1;

        // Directed fetch, byte load, byte RMW store.
        do_fetch(32'h10);
        do_data(1'b0, 2'd0, 32'h13, 64'd0);
        chk("t2_load_byte", d_rdata, 64'h0000_0011_2233_4455);
        do_data(1'b1, 2'd0, 32'h12, 64'hAB);
        chk("t3_merged_word", last_wr_data, 64'h1122_3344_55AB_7788);

        // Misaligned half store leaves memory untouched.
        do_data(1'b1, 2'd1, 32'h11, 64'h55AA);
        do_data(1'b0, 2'd3, 32'h10, 64'd0);
        chk("t5_mem_unchanged", d_rdata, 64'h1122_3344_55AB_7788);

        // Reset during the read phase of a byte RMW store.
        d_we    = 1'b1;
        d_size  = 2'd0;
        d_addr  = 32'h14;
        d_wdata = 64'hCD;
        d_req   = 1'b1;
        @(posedge clk); #1;
        chk("t6_busy_in_rd", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        d_req = 1'b0;
        chk("t6_idle_after_reset", 64'(busy), 64'd0);
        chk("t6_no_write", 64'(mem_wr), 64'd0);
        chk("t6_no_done", 64'(d_done), 64'd0);
        chk("t6_d_rdata_cleared", d_rdata, 64'd0);
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
        @(posedge clk); #1;
        chk("t6_still_idle", 64'({busy, mem_wr, d_done}), 64'd0);
        do_data(1'b0, 2'd3, 32'h10, 64'd0);
        chk("t6_mem_untouched", d_rdata, 64'h1122_3344_55AB_7788);
        do_data(1'b1, 2'd0, 32'h14, 64'hCD);
        do_data(1'b0, 2'd3, 32'h10, 64'd0);
        chk("t6_resubmit_result", d_rdata, 64'h1122_33CD_55AB_7788);

        // Randomized traffic against the reference model.
        for (int t = 0; t < 60; t++) begin
            ra = 32'($urandom_range(0, 127));
            rs = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) ra = ra & ~((32'd1 << rs) - 32'd1);
            if ($urandom_range(0, 3) == 0) do_fetch(ra);
            else do_data(1'($urandom_range(0, 1)), rs, ra, {$urandom, $urandom});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_port_sequencer.md
Name: mem_port_sequencer

Overview:
- Multicycle sequencer that shares one 64-bit, byte-addressed, registered memory port between the instruction-fetch requester and the load/store requester of the RV64 datapath.
- Arbitrates between the two requesters and sequences read latency.
- Performs read-modify-write for sb/sh/sw and flags misaligned data accesses.
- Sits between the main control FSM/datapath and the shared memory.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 64, memory word width (fixed 64; lane logic assumes 8 byte lanes)
MEM_LAT, 1, cycles from mem_addr first presented to mem_rdata valid (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request, held until if_done
if_addr  in  ADDR_W  fetch byte address
if_rdata  out  64  fetched doubleword, lane-shifted, held until next fetch
if_done  out  1  one-cycle completion pulse
d_req  in  1  data request, held until d_done
d_we  in  1  1=store, 0=load
d_size  in  2  0=byte, 1=half, 2=word, 3=dword
d_addr  in  ADDR_W  data byte address
d_wdata  in  64  store data, right-justified
d_rdata  out  64  load doubleword shifted right by d_addr[2:0]*8, held
d_done  out  1  one-cycle completion pulse
d_misalign  out  1  valid with d_done; access aborted
mem_addr  out  ADDR_W  {addr[ADDR_W-1:3],3'b000}
mem_wr  out  1  write strobe
mem_wdata  out  64  write data
mem_rdata  in  64  read data
busy  out  1  state != IDLE

Behaviour:
Reset (synchronous, also mid-operation):
- State -> IDLE; if_rdata, d_rdata, mem_wdata, mem_addr = 0; mem_wr, if_done, d_done, d_misalign = 0; last_grant = DATA.
- Any in-flight transaction is abandoned with no done pulse and no write.

States: IDLE, RD, CAPT, WR, DONE.

IDLE:
- Samples requests.
- Both high: grant the requester not equal to last_grant (round-robin). One high: grant it.
- Grant latches owner, address, size, we, wdata; last_grant updated on grant.
- Fetch or load -> RD.
- Store with d_size=3 -> WR.
- Store with d_size<3 -> RD (RMW).
- Misaligned data access -> DONE with d_misalign=1, no memory cycle. Misaligned means: half with addr[0]!=0; word with addr[1:0]!=0; dword with addr[2:0]!=0.
- Fetch addresses are never misaligned-checked.

RD:
- Lasts exactly MEM_LAT cycles, mem_addr stable, mem_wr=0. -> CAPT.

CAPT:
- mem_addr held.
- Load/fetch: owner rdata register <= mem_rdata >> (addr[2:0]*8) at cycle end; -> DONE.
- RMW: merge buffer <= (mem_rdata & ~mask) | ((wdata << addr[2:0]*8) & mask). Mask = 1/2/4 bytes at lane addr[2:0]. -> WR.

WR:
- Exactly one cycle with mem_wr=1.
- mem_wdata is the merge buffer (RMW) or d_wdata (dword). -> DONE.

DONE:
- Owner's done = 1 for this single cycle. -> IDLE.
- Requester must drop req at the edge ending the done cycle; a req still high in the following IDLE is a new request.

Latency (IDLE sampling cycle = 0):
- load/fetch: done in cycle MEM_LAT+2
- dword store: done in cycle 2
- RMW store: done in cycle MEM_LAT+3
- misaligned: done in cycle 1

Invariants:
- mem_wr never asserted outside WR.
- At most one done per cycle.
- Non-owner rdata never changes.
- Requests arriving while busy wait (no loss).

Decomposition:
- Package mem_seq_pkg: state enum (IDLE, RD, CAPT, WR, DONE); size codes SZ_B/SZ_H/SZ_W/SZ_D; owner enum OWN_IF/OWN_D; function lane_mask(size, off) returning the 64-bit byte-enable mask.
- Sub-module store_merge (combinational): inputs old word, wdata, size, offset; outputs merged word and misalign flag. Reused by the load path for the misalign check.

Test Plan:
1. Fetch if_addr=0x10, mem[0x10]=0x1122334455667788, MEM_LAT=1 -> if_done in cycle 3, if_rdata=0x1122334455667788, mem_wr never 1.
2. Load d_size=0, d_addr=0x13, mem[0x10]=0x1122334455667788 -> d_done cycle 3, d_rdata=0x0000001122334455.
3. Store byte d_addr=0x12, d_wdata=0xAB over mem[0x10]=0x1122334455667788 -> one mem_wr pulse in cycle 3, mem_wdata=0x1122334455AB7788, d_done cycle 4.
4. if_req and d_req both high from reset -> fetch granted first (last_grant=DATA at reset), data granted next; held both -> strict alternation IF, D, IF.
5. Store half d_addr=0x11 -> d_done and d_misalign in cycle 1, no mem_wr, memory unchanged.
6. reset asserted during RD of an RMW store -> next cycle IDLE, busy=0, no mem_wr, no d_done; resubmitted store completes normally.
